// File: rtl/pcm_fsk_frame_sequencer_if.sv
// Bus bundle between the frame sequencer, the PCM sampler, the shared Hamming
// encoder and the FSK modulator. The slave modport is the sequencer's view.
interface pcm_fsk_frame_sequencer_if;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       sample_ready;
    logic       ham_req;
    logic [3:0] ham_nibble;
    logic       ham_ack;
    logic [6:0] ham_code;
    logic       tx_bit;
    logic       tx_active;
    logic       sym_strobe;
    logic       frame_start;
    logic       underrun;

    modport slave (
        input  sample_valid, sample_data, ham_ack, ham_code,
        output sample_ready, ham_req, ham_nibble,
        output tx_bit, tx_active, sym_strobe, frame_start, underrun
    );

    modport master (
        output sample_valid, sample_data, ham_ack, ham_code,
        input  sample_ready, ham_req, ham_nibble,
        input  tx_bit, tx_active, sym_strobe, frame_start, underrun
    );
endinterface

// File: rtl/pcm_fsk_frame_sequencer.sv
// PCM -> Hamming(7,4) -> FSK transmit sequencer: buffers one sample, fetches its two
// codewords from the shared encoder and serialises them behind a sync word.
module pcm_fsk_frame_sequencer #(
    parameter int unsigned BIT_CYCLES    = 16,
    parameter int unsigned FRAME_SAMPLES = 4,
    parameter logic [7:0]  SYNC_WORD     = 8'hA5
) (
    input  logic                     clk,
    input  logic                     reset,
    pcm_fsk_frame_sequencer_if.slave bus
);
    localparam int unsigned SCW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int unsigned NCW = 2 * FRAME_SAMPLES;
    localparam int unsigned CWW = (NCW > 1) ? $clog2(NCW) : 1;
    localparam logic [SCW-1:0] SYM_LAST = SCW'(BIT_CYCLES - 1);
    localparam logic [CWW-1:0] CW_LAST  = CWW'(NCW - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_SYNC = 2'd1, S_DATA = 2'd2} state_e;

    logic [7:0]     sbuf_q, sbuf_d;
    logic           sbuf_valid_q, sbuf_valid_d;
    logic           sample_ready_q, sample_ready_d;
    logic           nib_sel_q, nib_sel_d;
    logic           ham_req_q, ham_req_d;
    logic [3:0]     ham_nibble_q, ham_nibble_d;
    logic [6:0]     next_code_q, next_code_d;
    logic           next_valid_q, next_valid_d;
    logic           accept_s, ack_s, load_s, take_s;

    state_e         state_q, state_d;
    logic [SCW-1:0] sym_cnt_q, sym_cnt_d;
    logic [2:0]     bit_idx_q, bit_idx_d;
    logic [CWW-1:0] cw_cnt_q, cw_cnt_d;
    logic [6:0]     code_q, code_d;

    logic tx_bit_q, tx_bit_d, tx_active_q, tx_active_d, sym_strobe_q, sym_strobe_d;
    logic frame_start_q, frame_start_d, underrun_q, underrun_d;

    // Fetch engine: sample buffer, encoder handshake and the one-deep codeword slot.
    // A codeword taken by the TX side frees the slot; an ack can only arrive while it is empty.
    always_comb begin
        accept_s       = bus.sample_valid && sample_ready_q;
        ack_s          = bus.ham_ack && ham_req_q;
        take_s         = load_s && next_valid_q;
        sbuf_d         = accept_s ? bus.sample_data : sbuf_q;
        sbuf_valid_d   = sbuf_valid_q || accept_s;
        nib_sel_d      = nib_sel_q;
        ham_nibble_d   = ham_nibble_q;
        next_code_d    = next_code_q;
        next_valid_d   = next_valid_q && !take_s;
        if (ack_s) begin
            next_code_d  = bus.ham_code;
            next_valid_d = 1'b1;
            ham_req_d    = 1'b0;
            nib_sel_d    = !nib_sel_q;
            sbuf_valid_d = sbuf_valid_q && !nib_sel_q;
        end else if (!next_valid_q && sbuf_valid_q && !ham_req_q) begin
            ham_req_d    = 1'b1;
            ham_nibble_d = nib_sel_q ? sbuf_q[3:0] : sbuf_q[7:4];
        end else begin
            ham_req_d    = ham_req_q;
        end
        sample_ready_d = !sbuf_valid_d;
    end

    // Fetch engine registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sbuf_q         <= 8'd0;
            sbuf_valid_q   <= 1'b0;
            sample_ready_q <= 1'b1;
            nib_sel_q      <= 1'b0;
            ham_req_q      <= 1'b0;
            ham_nibble_q   <= 4'd0;
            next_code_q    <= 7'd0;
            next_valid_q   <= 1'b0;
        end else begin
            sbuf_q         <= sbuf_d;
            sbuf_valid_q   <= sbuf_valid_d;
            sample_ready_q <= sample_ready_d;
            nib_sel_q      <= nib_sel_d;
            ham_req_q      <= ham_req_d;
            ham_nibble_q   <= ham_nibble_d;
            next_code_q    <= next_code_d;
            next_valid_q   <= next_valid_d;
        end
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            sym_cnt_q <= {SCW{1'b0}};
            bit_idx_q <= 3'd0;
            cw_cnt_q  <= {CWW{1'b0}};
            code_q    <= 7'd0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            bit_idx_q <= bit_idx_d;
            cw_cnt_q  <= cw_cnt_d;
            code_q    <= code_d;
        end
    end

    // TX next-state: everything advances only when the symbol counter wraps.
    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        bit_idx_d = bit_idx_q;
        cw_cnt_d  = cw_cnt_q;
        code_d    = code_q;
        load_s    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (sbuf_valid_q) begin
                    state_d   = S_SYNC;
                    sym_cnt_d = {SCW{1'b0}};
                    bit_idx_d = 3'd0;
                end else begin
                    state_d   = S_IDLE;
                end
            end
            S_SYNC: begin
                if (sym_cnt_q != SYM_LAST) begin
                    sym_cnt_d = sym_cnt_q + SCW'(1);
                end else if (bit_idx_q == 3'd7) begin
                    sym_cnt_d = {SCW{1'b0}};
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    cw_cnt_d  = {CWW{1'b0}};
                    load_s    = 1'b1;
                    code_d    = next_valid_q ? next_code_q : 7'd0;
                end else begin
                    sym_cnt_d = {SCW{1'b0}};
                    bit_idx_d = bit_idx_q + 3'd1;
                end
            end
            S_DATA: begin
                if (sym_cnt_q != SYM_LAST) begin
                    sym_cnt_d = sym_cnt_q + SCW'(1);
                end else if (bit_idx_q != 3'd6) begin
                    sym_cnt_d = {SCW{1'b0}};
                    bit_idx_d = bit_idx_q + 3'd1;
                    code_d    = {code_q[5:0], 1'b0};
                end else if (cw_cnt_q != CW_LAST) begin
                    sym_cnt_d = {SCW{1'b0}};
                    bit_idx_d = 3'd0;
                    cw_cnt_d  = cw_cnt_q + CWW'(1);
                    load_s    = 1'b1;
                    code_d    = next_valid_q ? next_code_q : 7'd0;
                end else begin
                    // Pending work chains straight into the next sync word, no gap symbol.
                    sym_cnt_d = {SCW{1'b0}};
                    bit_idx_d = 3'd0;
                    state_d   = (sbuf_valid_q || next_valid_q) ? S_SYNC : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // TX outputs, derived from the next state so the registered copies line up with it.
    always_comb begin
        tx_active_d   = (state_d != S_IDLE);
        sym_strobe_d  = tx_active_d && (sym_cnt_d == {SCW{1'b0}});
        frame_start_d = (state_d == S_SYNC) && (bit_idx_d == 3'd0) && (sym_cnt_d == {SCW{1'b0}});
        underrun_d    = load_s && !next_valid_q;
        case (state_d)
            S_SYNC:  tx_bit_d = SYNC_WORD[3'd7 - bit_idx_d];
            S_DATA:  tx_bit_d = code_d[6];
            default: tx_bit_d = 1'b0;
        endcase
    end

    // TX output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_bit_q      <= 1'b0;
            tx_active_q   <= 1'b0;
            sym_strobe_q  <= 1'b0;
            frame_start_q <= 1'b0;
            underrun_q    <= 1'b0;
        end else begin
            tx_bit_q      <= tx_bit_d;
            tx_active_q   <= tx_active_d;
            sym_strobe_q  <= sym_strobe_d;
            frame_start_q <= frame_start_d;
            underrun_q    <= underrun_d;
        end
    end

    assign bus.sample_ready = sample_ready_q;
    assign bus.ham_req      = ham_req_q;
    assign bus.ham_nibble   = ham_nibble_q;
    assign bus.tx_bit       = tx_bit_q;
    assign bus.tx_active    = tx_active_q;
    assign bus.sym_strobe   = sym_strobe_q;
    assign bus.frame_start  = frame_start_q;
    assign bus.underrun     = underrun_q;
endmodule

// File: tb/tb_pcm_fsk_frame_sequencer.sv
// Directed bench: three sequencers (FRAME_SAMPLES 1, 2, 4; BIT_CYCLES 4) with
// encoder responders and symbol monitors; expected streams are hand-computed.
module tb_pcm_fsk_frame_sequencer;
    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;
    int   n_check = 0;
    int   n_fail  = 0;
    int   cyc     = 0;

    pcm_fsk_frame_sequencer_if ia();
    pcm_fsk_frame_sequencer_if ib();
    pcm_fsk_frame_sequencer_if ic();

    pcm_fsk_frame_sequencer #(.BIT_CYCLES(4), .FRAME_SAMPLES(1), .SYNC_WORD(8'hA5))
        u_a (.clk(clk), .reset(rst_a), .bus(ia.slave));
    pcm_fsk_frame_sequencer #(.BIT_CYCLES(4), .FRAME_SAMPLES(2), .SYNC_WORD(8'hA5))
        u_b (.clk(clk), .reset(rst_b), .bus(ib.slave));
    pcm_fsk_frame_sequencer #(.BIT_CYCLES(4), .FRAME_SAMPLES(4), .SYNC_WORD(8'hA5))
        u_c (.clk(clk), .reset(rst_c), .bus(ic.slave));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] ham7(input logic [3:0] n);
        return {n, n[3] ^ n[2] ^ n[0], n[3] ^ n[1] ^ n[0], n[2] ^ n[1] ^ n[0]};
    endfunction

    // Encoder responders: ack a held request after a programmable wait.
    int da = 1, db = 1, dc = 1;
    int wa = 0, wb = 0, wc = 0;
    int na = 0, nb = 0, nc = 0;
    always @(posedge clk) begin
        if (rst_a || !ia.ham_req || ia.ham_ack) begin
            ia.ham_ack <= 1'b0; wa <= 0;
        end else if (wa >= da) begin
            ia.ham_ack <= 1'b1; ia.ham_code <= ham7(ia.ham_nibble); wa <= 0; na <= na + 1;
        end else wa <= wa + 1;
    end
    always @(posedge clk) begin
        if (rst_b || !ib.ham_req || ib.ham_ack) begin
            ib.ham_ack <= 1'b0; wb <= 0;
        end else if (wb >= db) begin
            ib.ham_ack <= 1'b1; ib.ham_code <= ham7(ib.ham_nibble); wb <= 0; nb <= nb + 1;
        end else wb <= wb + 1;
    end
    always @(posedge clk) begin
        if (rst_c || !ic.ham_req || ic.ham_ack) begin
            ic.ham_ack <= 1'b0; wc <= 0;
        end else if (wc >= dc) begin
            ic.ham_ack <= 1'b1; ic.ham_code <= ham7(ic.ham_nibble); wc <= 0; nc <= nc + 1;
        end else wc <= wc + 1;
    end

    // Symbol monitors, sampled on the falling edge.
    logic [63:0] a_bits, b_bits;
    int a_act = 0, a_sym = 0, a_fs = 0, a_und = 0, b_und = 0;
    int c_act = 0, c_fs = 0, c_und = 0, c_drop = 0, c_fs_last = 0, c_fs_prev = 0;
    logic c_prev = 1'b0;
    always @(negedge clk) begin
        if (ia.tx_active === 1'b1) a_act <= a_act + 1;
        if (ia.sym_strobe === 1'b1) begin a_sym <= a_sym + 1; a_bits <= {a_bits[62:0], ia.tx_bit}; end
        if (ia.frame_start === 1'b1) a_fs <= a_fs + 1;
        if (ia.underrun === 1'b1) a_und <= a_und + 1;
        if (ib.sym_strobe === 1'b1) b_bits <= {b_bits[62:0], ib.tx_bit};
        if (ib.underrun === 1'b1) b_und <= b_und + 1;
        if (ic.tx_active === 1'b1) c_act <= c_act + 1;
        if (ic.underrun === 1'b1) c_und <= c_und + 1;
        if (ic.frame_start === 1'b1) begin c_fs <= c_fs + 1; c_fs_prev <= c_fs_last; c_fs_last <= cyc; end
        if (c_prev && (ic.tx_active !== 1'b1)) c_drop <= c_drop + 1;
        c_prev <= (ic.tx_active === 1'b1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_check++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic rdy(input int w);
        case (w)
            0:       return ia.sample_ready;
            1:       return ib.sample_ready;
            default: return ic.sample_ready;
        endcase
    endfunction

    function automatic logic act(input int w);
        case (w)
            0:       return ia.tx_active;
            1:       return ib.tx_active;
            default: return ic.tx_active;
        endcase
    endfunction

    task automatic set_in(input int w, input logic v, input logic [7:0] d);
        case (w)
            0:       begin ia.sample_valid = v; ia.sample_data = d; end
            1:       begin ib.sample_valid = v; ib.sample_data = d; end
            default: begin ic.sample_valid = v; ic.sample_data = d; end
        endcase
    endtask

    // Offer one sample and hold it until accepted (bounded).
    task automatic send(input int w, input logic [7:0] d);
        int n = 0;
        set_in(w, 1'b1, d);
        while (rdy(w) !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
        chk("send_ready", rdy(w), 1'b1);
        @(posedge clk); #1;
        set_in(w, 1'b0, d);
    endtask

    // Wait for the current frame run to start and then end (bounded).
    task automatic wait_done(input int w);
        int n = 0;
        while (act(w) !== 1'b1 && n < 400) begin @(negedge clk); n++; end
        while (act(w) === 1'b1 && n < 4000) begin @(negedge clk); n++; end
        chk("frame_end", act(w), 1'b0);
        @(negedge clk);
    endtask

    int s_act, s_sym, s_fs, s_und, s_na;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        set_in(0, 1'b0, 8'h00); set_in(1, 1'b0, 8'h00); set_in(2, 1'b0, 8'h00);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_tx_active", ia.tx_active, 1'b0);
        chk("rst_sample_ready", ia.sample_ready, 1'b1);
        chk("rst_ham_req", ia.ham_req, 1'b0);
        chk("rst_tx_bit", ia.tx_bit, 1'b0);
        chk("rst_sym_strobe", ia.sym_strobe, 1'b0);
        chk("rst_underrun", ia.underrun, 1'b0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Reset held 5 cycles in the middle of a frame aborts it.
        send(0, 8'h55);
        repeat (40) @(negedge clk);
        chk("t1_active_pre", ia.tx_active, 1'b1);
        @(posedge clk); #1; rst_a = 1'b1;
        repeat (5) @(posedge clk);
        #1; rst_a = 1'b0;
        @(negedge clk);
        chk("t1_tx_active", ia.tx_active, 1'b0);
        chk("t1_ham_req", ia.ham_req, 1'b0);
        chk("t1_sample_ready", ia.sample_ready, 1'b1);
        repeat (100) @(negedge clk);
        chk("t1_no_flush", ia.tx_active, 1'b0);

        // One sample, one-sample frame.
        s_act = a_act; s_sym = a_sym; s_fs = a_fs; s_und = a_und;
        @(posedge clk); #1;
        send(0, 8'h3C);
        wait_done(0);
        chk("t2_bits", {42'd0, a_bits[21:0]}, {42'd0, 8'hA5, 7'b0011100, 7'b1100011});
        chk("t2_active_cycles", a_act - s_act, 88);
        chk("t2_strobes", a_sym - s_sym, 22);
        chk("t2_frame_starts", a_fs - s_fs, 1);
        chk("t2_underrun", a_und - s_und, 0);
        chk("t2_ready_idle", ia.sample_ready, 1'b1);

        // Second sample held while the buffer is full: accepted only after the low-nibble ack.
        s_act = a_act; s_fs = a_fs; s_na = na;
        @(posedge clk); #1;
        send(0, 8'h3C);
        set_in(0, 1'b1, 8'h96);
        begin
            int n = 0;
            while (ia.sample_ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
        end
        chk("t6_acks_before_ready", na - s_na, 2);
        @(posedge clk); #1;
        set_in(0, 1'b0, 8'h00);
        wait_done(0);
        chk("t6_bits", {20'd0, a_bits[43:0]},
            {20'd0, 8'hA5, 7'b0011100, 7'b1100011, 8'hA5, 7'b1001001, 7'b0110110});
        chk("t6_frame_starts", a_fs - s_fs, 2);
        chk("t6_active_cycles", a_act - s_act, 176);

        // Two-sample frame with a single sample: two fillers.
        s_und = b_und;
        send(1, 8'h96);
        wait_done(1);
        chk("t3_bits", {28'd0, b_bits[35:0]},
            {28'd0, 8'hA5, 7'b1001001, 7'b0110110, 7'b0000000, 7'b0000000});
        chk("t3_underruns", b_und - s_und, 2);

        // Slow encoder: filler first, late codeword at the following boundary.
        db = 36;
        s_und = b_und;
        @(posedge clk); #1;
        send(1, 8'h5A);
        wait_done(1);
        chk("t5_bits", {28'd0, b_bits[35:0]},
            {28'd0, 8'hA5, 7'b0000000, 7'b0101010, 7'b0000000, 7'b1010101});
        chk("t5_underruns", b_und - s_und, 2);

        // Continuous stream: three back-to-back frames.
        s_act = c_act; s_fs = c_fs; s_und = c_und;
        begin
            int drop0 = c_drop;
            for (int i = 0; i < 12; i++) send(2, 8'h10 + 8'(i * 17));
            wait_done(2);
            chk("t4_frame_starts", c_fs - s_fs, 3);
            chk("t4_fs_interval", c_fs_last - c_fs_prev, 256);
            chk("t4_underrun", c_und - s_und, 0);
            chk("t4_active_cycles", c_act - s_act, 768);
            chk("t4_single_drop", c_drop - drop0, 1);
        end

        $display("%0d/%0d checks passed", n_check - n_fail, n_check);
        $finish;
    end
endmodule
